// File: rtl/control_unit.sv
// Decode and control block for the 8-bit multi-cycle CPU.
// Combinational strobe/next-state decode plus a sticky halted flag.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic [2:0] state,
  input  logic       zf,
  output logic [2:0] next_state,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       pc_jmp_sel,
  output logic [3:0] pc_offset,
  output logic       addr_sel,
  output logic [3:0] addr_offset,
  output logic       mem_sel,
  output logic       mem_we,
  output logic [2:0] alu_opcode,
  output logic       alu_sel_a,
  output logic       alu_sel_b,
  output logic       alu_we,
  output logic       zf_we,
  output logic       ir_we,
  output logic       a_sel,
  output logic       a_we,
  output logic       b_sel,
  output logic       b_we,
  output logic       halt
);

  typedef enum logic [2:0] {
    FETCH      = 3'b000,
    DECODE     = 3'b001,
    EXECUTE    = 3'b010,
    MEMORY     = 3'b011,
    WRITEBACK  = 3'b100,
    HALT_STATE = 3'b101,
    IDLE       = 3'b110,
    UNUSED     = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_ALU   = 3'b001,
    OP_ADDI  = 3'b010,
    OP_LOAD  = 3'b011,
    OP_STORE = 3'b100,
    OP_JMP   = 3'b101,
    OP_JZ    = 3'b110,
    OP_HLT   = 3'b111
  } opcode_t;

  state_t     cur;
  opcode_t    op;
  logic       reg_b;
  logic [3:0] imm4;
  logic       is_alu;
  logic       halted;

  assign cur    = state_t'(state);
  assign op     = opcode_t'(instr[7:5]);
  assign reg_b  = instr[4];
  assign imm4   = instr[3:0];
  assign is_alu = (op == OP_ALU) || (op == OP_ADDI);

  // The state register lives outside; the only local storage is this flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      halted <= 1'b0;
    else if (cur == HALT_STATE)
      halted <= 1'b1;
  end

  always_comb begin
    next_state = FETCH;
    if (!reset) begin
      case (cur)
        FETCH:      next_state = DECODE;
        DECODE:     next_state = (op == OP_NOP) ? IDLE :
                                 (op == OP_HLT) ? HALT_STATE : EXECUTE;
        EXECUTE:    next_state = is_alu ? WRITEBACK :
                                 (op == OP_LOAD || op == OP_STORE) ? MEMORY : IDLE;
        MEMORY:     next_state = (op == OP_LOAD) ? WRITEBACK : IDLE;
        WRITEBACK:  next_state = IDLE;
        HALT_STATE: next_state = HALT_STATE;
        IDLE:       next_state = FETCH;
        default:    next_state = FETCH;
      endcase
    end
  end

  always_comb begin
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    pc_jmp_sel  = 1'b0;
    pc_offset   = '0;
    addr_sel    = 1'b0;
    addr_offset = '0;
    mem_sel     = 1'b0;
    mem_we      = 1'b0;
    alu_opcode  = '0;
    alu_sel_a   = 1'b0;
    alu_sel_b   = 1'b0;
    alu_we      = 1'b0;
    zf_we       = 1'b0;
    ir_we       = 1'b0;
    a_sel       = 1'b0;
    a_we        = 1'b0;
    b_sel       = 1'b0;
    b_we        = 1'b0;
    halt        = 1'b0;
    if (!reset) begin
      halt = (cur == HALT_STATE) || halted;
      case (cur)
        FETCH: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
        EXECUTE: begin
          case (op)
            OP_ALU: begin
              alu_opcode = instr[2:0];
              alu_we     = 1'b1;
              zf_we      = 1'b1;
            end
            OP_ADDI: begin
              alu_sel_a = reg_b;
              alu_sel_b = 1'b1;
              alu_we    = 1'b1;
              zf_we     = 1'b1;
            end
            OP_JMP: begin
              pc_we     = 1'b1;
              pc_sel    = 1'b1;
              pc_offset = imm4;
            end
            OP_JZ: begin
              pc_we      = zf;
              pc_sel     = 1'b1;
              pc_jmp_sel = 1'b1;
              pc_offset  = imm4;
            end
            default: ;
          endcase
        end
        MEMORY: begin
          addr_sel    = 1'b1;
          addr_offset = imm4;
          if (op == OP_STORE) begin
            mem_we  = 1'b1;
            mem_sel = reg_b;
          end
        end
        WRITEBACK: begin
          if (is_alu || op == OP_LOAD) begin
            a_we  = ~reg_b;
            b_we  = reg_b;
            a_sel = (op == OP_LOAD);
            b_sel = (op == OP_LOAD);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed test-plan cases plus randomized
// state/instr/zf/reset stimulus against a rule-based reference model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic [2:0] state;
  logic       zf;
  logic [2:0] next_state;
  logic       pc_we, pc_sel, pc_jmp_sel;
  logic [3:0] pc_offset;
  logic       addr_sel;
  logic [3:0] addr_offset;
  logic       mem_sel, mem_we;
  logic [2:0] alu_opcode;
  logic       alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
  logic       a_sel, a_we, b_sel, b_we, halt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        halted_m = 1'b0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .instr(instr), .state(state), .zf(zf),
    .next_state(next_state), .pc_we(pc_we), .pc_sel(pc_sel),
    .pc_jmp_sel(pc_jmp_sel), .pc_offset(pc_offset), .addr_sel(addr_sel),
    .addr_offset(addr_offset), .mem_sel(mem_sel), .mem_we(mem_we),
    .alu_opcode(alu_opcode), .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b),
    .alu_we(alu_we), .zf_we(zf_we), .ir_we(ir_we), .a_sel(a_sel),
    .a_we(a_we), .b_sel(b_sel), .b_we(b_we), .halt(halt)
  );

  logic [29:0] got;
  assign got = {next_state, pc_we, pc_sel, pc_jmp_sel, pc_offset, addr_sel,
                addr_offset, mem_sel, mem_we, alu_opcode, alu_sel_a, alu_sel_b,
                alu_we, zf_we, ir_we, a_sel, a_we, b_sel, b_we, halt};

  task automatic check_eq(input string tag, input logic [29:0] actual,
                          input logic [29:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (state=%0d instr=%h zf=%0b rst=%0b)",
               tag, actual, expected, state, instr, zf, reset);
    end
  endtask

  // Each output written as a rule over (state, opcode) rather than a case walk.
  function automatic logic [29:0] model(input logic rst, input int unsigned st,
                                        input logic [7:0] ins, input logic z,
                                        input logic hf);
    int unsigned op = ins[7:5];
    logic [3:0]  imm = ins[3:0];
    logic        rb = ins[4];
    logic        alu = (op == 1) || (op == 2);
    logic        jmp = (st == 2) && (op == 5 || op == 6);
    logic        wb  = (st == 4) && (alu || op == 3);
    int unsigned ns;
    logic [2:0]  ns3, aop;
    if (rst) return '0;
    case (st)
      0: ns = 1;
      1: ns = (op == 0) ? 6 : (op == 7) ? 5 : 2;
      2: ns = alu ? 4 : (op == 3 || op == 4) ? 3 : 6;
      3: ns = (op == 3) ? 4 : 6;
      4: ns = 6;
      5: ns = 5;
      default: ns = 0;
    endcase
    ns3 = ns[2:0];
    aop = (st == 2 && op == 1) ? ins[2:0] : 3'b000;
    return {ns3,
            (st == 0) || (st == 2 && (op == 5 || (op == 6 && z))),
            jmp,
            (st == 2 && op == 6),
            jmp ? imm : 4'h0,
            (st == 3),
            (st == 3) ? imm : 4'h0,
            (st == 3 && op == 4 && rb),
            (st == 3 && op == 4),
            aop,
            (st == 2 && op == 2 && rb),
            (st == 2 && op == 2),
            (st == 2 && alu),
            (st == 2 && alu),
            (st == 0),
            (st == 4 && op == 3),
            wb && !rb,
            (st == 4 && op == 3),
            wb && rb,
            (st == 5) || hf};
  endfunction

  task automatic step(input string tag, input logic rst, input logic [2:0] st,
                      input logic [7:0] ins, input logic z);
    @(negedge clk);
    reset = rst; state = st; instr = ins; zf = z;
    if (rst) halted_m = 1'b0;
    #2;
    check_eq(tag, got, model(rst, st, ins, z, halted_m));
    @(posedge clk);
    if (!rst && st == 3'd5) halted_m = 1'b1;
  endtask

  initial begin
    reset = 1'b1; state = '0; instr = '0; zf = 1'b0;
    step("reset_zero", 1'b1, 3'd2, 8'h32, 1'b1);
    check_eq("reset_const", got, 30'h0);
    step("reset_halt", 1'b1, 3'd5, 8'hE0, 1'b0);
    step("mem_load_a15", 1'b0, 3'd3, 8'h6F, 1'b0);
    step("mem_load_b3", 1'b0, 3'd3, 8'h73, 1'b0);
    step("mem_store_a15", 1'b0, 3'd3, 8'h8F, 1'b0);
    step("mem_store_b3", 1'b0, 3'd3, 8'h93, 1'b0);
    step("mem_jmp", 1'b0, 3'd3, 8'hA7, 1'b0);
    step("fetch", 1'b0, 3'd0, 8'h5A, 1'b1);
    step("decode_hlt", 1'b0, 3'd1, 8'hE0, 1'b0);
    step("decode_nop", 1'b0, 3'd1, 8'h1F, 1'b0);
    step("exec_jz_zf0", 1'b0, 3'd2, 8'hC5, 1'b0);
    step("exec_jz_zf1", 1'b0, 3'd2, 8'hC5, 1'b1);
    step("exec_jmp", 1'b0, 3'd2, 8'hBF, 1'b0);
    step("exec_alu_b", 1'b0, 3'd2, 8'h32, 1'b0);
    step("wb_alu_b", 1'b0, 3'd4, 8'h32, 1'b0);
    step("exec_addi_b", 1'b0, 3'd2, 8'h59, 1'b1);
    step("wb_load_a", 1'b0, 3'd4, 8'h64, 1'b0);
    step("unused_enc", 1'b0, 3'd7, 8'hFF, 1'b1);
    step("idle", 1'b0, 3'd6, 8'h00, 1'b0);
    step("halt_state", 1'b0, 3'd5, 8'hE0, 1'b0);
    step("halt_sticky", 1'b0, 3'd0, 8'h00, 1'b0);
    check_eq("halt_bit", {29'b0, halt}, 30'h1);
    step("halt_cleared", 1'b1, 3'd0, 8'h00, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step("random", ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
           8'($urandom), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Decode and control block of the 8-bit multi-cycle CPU.
- Takes the current FSM state from the external state register, the instruction register contents and the zero flag.
- Combinationally produces the next state and every datapath strobe: PC, address mux, memory, ALU, IR and the A/B registers.
- Its only storage is a sticky halted flag.

Parameters:
- none (widths fixed: 8-bit instruction, 3-bit state, 4-bit offsets)

Ports:
- clk  input  1  system clock; used only by the sticky halted flag
- reset  input  1  asynchronous, active-high
- instr  input  8  instruction: [7:5] opcode, [4] register select (0=A, 1=B), [3:0] imm4
- state  input  3  current state: FETCH=000, DECODE=001, EXECUTE=010, MEMORY=011, WRITEBACK=100, HALT_STATE=101, IDLE=110
- zf  input  1  zero flag
- next_state  output  3  next FSM state
- pc_we  output  1  PC write enable
- pc_sel  output  1  PC source: 0=PC+1, 1=jump target
- pc_jmp_sel  output  1  jump kind: 0=unconditional, 1=conditional
- pc_offset  output  4  jump target offset
- addr_sel  output  1  memory address source: 0=PC, 1=addr_offset
- addr_offset  output  4  data address
- mem_sel  output  1  store data source: 0=A, 1=B
- mem_we  output  1  memory write enable
- alu_opcode  output  3  ALU operation
- alu_sel_a  output  1  ALU A operand: 0=reg A, 1=reg B
- alu_sel_b  output  1  ALU B operand: 0=reg B, 1=zero-extended imm4
- alu_we  output  1  ALU result register enable
- zf_we  output  1  zero flag enable
- ir_we  output  1  instruction register enable
- a_sel  output  1  A write data: 0=ALU result, 1=memory data
- a_we  output  1  A write enable
- b_sel  output  1  B write data: 0=ALU result, 1=memory data
- b_we  output  1  B write enable
- halt  output  1  halt indicator

Behaviour:
- Purely combinational decode; all outputs are 0 unless listed below.
- Reset high: all outputs 0, next_state=FETCH, independent of the other inputs. Reset asynchronously clears the halted flag.

Opcodes:
- 000 NOP
- 001 ALU reg-reg: alu_opcode=instr[2:0]; destination selected by instr[4]
- 010 ADDI: alu_opcode=000; alu_sel_a=instr[4]; alu_sel_b=1; destination selected by instr[4]
- 011 LOAD
- 100 STORE
- 101 JMP
- 110 JZ
- 111 HLT

State FETCH:
- addr_sel=0, ir_we=1, pc_we=1, pc_sel=0
- next=DECODE

State DECODE:
- next=IDLE for NOP, HALT_STATE for HLT, otherwise EXECUTE

State EXECUTE:
- ALU/ADDI: alu_opcode and operand selects as above; alu_we=1; zf_we=1; next=WRITEBACK.
- LOAD/STORE: next=MEMORY.
- JMP: pc_we=1, pc_sel=1, pc_jmp_sel=0, pc_offset=imm4; next=IDLE.
- JZ: pc_sel=1, pc_jmp_sel=1, pc_offset=imm4, pc_we=zf; next=IDLE.
- Any other opcode: next=IDLE.

State MEMORY:
- All opcodes: addr_sel=1, addr_offset=imm4.
- LOAD: mem_we=0, mem_sel=0; next=WRITEBACK.
- STORE: mem_we=1, mem_sel=instr[4]; next=IDLE.
- Any other opcode: addr outputs still driven; next=IDLE.

State WRITEBACK:
- ALU/ADDI: a_we=~instr[4], b_we=instr[4], a_sel=b_sel=0.
- LOAD: same enables with a_sel=b_sel=1.
- Next=IDLE.

Other states:
- IDLE: next=FETCH.
- HALT_STATE: halt=1; next=HALT_STATE.
- Unused encoding 111: all outputs 0; next=FETCH.

Halted flag:
- Set on the rising clk edge when state=HALT_STATE and reset=0.
- halt output = (state==HALT_STATE) | halted flag.

Boundaries:
- All pc/addr offsets are raw imm4 (no sign extension).
- zf is consulted only for JZ in EXECUTE.

Test Plan:
- Reset=1, any state/instr: all outputs 0, next_state=FETCH.
- MEMORY, instr=0x6F (LOAD A,15): next=WRITEBACK, addr_sel=1, addr_offset=1111, mem_sel=0, mem_we=0, all else 0. Same for 0x73 (LOAD B,3) with addr_offset=0011.
- MEMORY, instr=0x8F (STORE A,15): next=IDLE, addr_offset=1111, addr_sel=1, mem_sel=0, mem_we=1. instr=0x93 (STORE B,3): same with addr_offset=0011, mem_sel=1.
- FETCH, any instr: ir_we=1, pc_we=1, pc_sel=0, addr_sel=0, next=DECODE. DECODE, instr=0xE0: next=HALT_STATE.
- EXECUTE, instr=0xC5 (JZ 5): zf=0 gives pc_we=0; zf=1 gives pc_we=1, pc_sel=1, pc_jmp_sel=1, pc_offset=0101; next=IDLE in both cases.
- EXECUTE, instr=0x32 (ALU B, op 010): alu_opcode=010, alu_we=1, zf_we=1, next=WRITEBACK. Then WRITEBACK with the same instr: b_we=1, b_sel=0, a_we=0.
